seq_shift_register: RTL and testbench
=====================================

Name: seq_shift_register

Overview:
- Parametrised multi-step shift/rotate register. Successor to the fixed 4-bit rotate/arith-shift register.
- Adds configurable width, a shift-amount sequencer with busy/done handshake, logical/arithmetic/rotate/serial modes, and shift-out capture.
- Used by lab datapaths that need an N-position shift executed one position per clock, with completion signalled to a controller.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AMT_W, 4, width of the shift-amount input. Amounts up to 2^AMT_W-1 are legal.

Ports:
- clock  input  1  single system clock, rising-edge active.
- resetn  input  1  asynchronous, active-low reset.
- load_n  input  1  active-low parallel load strobe.
- data_in  input  WIDTH  parallel load data.
- start  input  1  begin a sequenced shift operation (sampled at rising edge).
- op  input  3  operation code, latched at start.
- amount  input  AMT_W  number of single-position steps, latched at start.
- serial_in  input  1  fill bit for the serial modes.
- q  output  WIDTH  register contents.
- shift_out  output  1  bit most recently shifted or rotated out.
- busy  output  1  high while steps remain.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (resetn=0, asynchronous, any time): q=0, shift_out=0, busy=0, done=0, state=IDLE. Latched op/amount are cleared. Takes effect immediately, including mid-operation.
- States: IDLE, SHIFT, DONE. busy=1 only in SHIFT; done=1 only in DONE.
- IDLE or DONE, load_n=0 at edge: q<=data_in, next state IDLE. load_n has priority over start; start is ignored on that edge.
- IDLE or DONE, load_n=1, start=1 at edge: latch op and amount into internal count. Next state SHIFT if amount!=0. If amount==0, next state DONE and q is unchanged.
- IDLE or DONE with no load and no start: DONE goes to IDLE; q holds.
- SHIFT, each edge: perform one step per the latched op and decrement count. If count was 1, next state DONE; otherwise stay in SHIFT.
- Latency: start accepted at edge k -> steps at edges k+1..k+amount -> done high for the cycle after edge k+amount -> IDLE after edge k+amount+1.
- SHIFT, start=1: ignored. Changes on op/amount during SHIFT have no effect.
- SHIFT, load_n=0: abort. q<=data_in, count cleared, next state IDLE, no done pulse.
- Op codes, one step, b = bit leaving the register:
  - 000: nop. q holds, shift_out holds. The step still counts.
  - 001: SLL. q<={q[W-2:0],0}, b=q[W-1].
  - 010: SRL. q<={0,q[W-1:1]}, b=q[0].
  - 011: SRA. q<={q[W-1],q[W-1:1]}, b=q[0].
  - 100: ROL. q<={q[W-2:0],q[W-1]}, b=q[W-1].
  - 101: ROR. q<={q[0],q[W-1:1]}, b=q[0].
  - 110: serial left. q<={q[W-2:0],serial_in}, b=q[W-1]. serial_in is sampled at every step edge.
  - 111: serial right. q<={serial_in,q[W-1:1]}, b=q[0].
- For every op except nop, shift_out<=b on each step edge. shift_out changes only on step edges, load does not change it, and it holds after DONE.
- amount > WIDTH: all steps are executed. Logical results become 0, SRA saturates to all sign bits, and rotates wrap modulo WIDTH.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset mid-SHIFT: load 8'hA5, start op=101 amount=5, assert resetn=0 after 2 steps -> q=0, busy=0, done=0 immediately, with no done pulse later.
- ROR sequence: load 8'h81, start op=101 amount=3 -> q=8'hC0, 8'h60, 8'h30 on successive edges. busy is high for 3 cycles, then done for 1 cycle, and shift_out=0.
- SRA sign fill and saturation: load 8'h90, start op=011 amount=2 -> q=8'hE4. Then start amount=12 -> q=8'hFF, shift_out=1.
- Serial left: load 8'h00, start op=110 amount=4 with serial_in=1,0,1,1 on steps -> q=8'h0B.
- Zero amount and priority: start amount=0 -> done the next cycle, busy never high, q unchanged. Same-edge load_n=0 and start=1 with data_in=8'h3C -> q=8'h3C, no operation started.
- Abort and ignored start: start op=001 amount=6 on 8'h01, then start again after 2 steps (ignored), then load_n=0 with 8'h55 after 3 steps -> q=8'h55, IDLE, no done pulse.

Source files
------------

// File: rtl/seq_shift_register.sv
// Multi-step shift/rotate register: executes an N-position shift one position per clock
// and reports progress through busy and a one-cycle done pulse.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for load or start
// S_SHIFT | one step per edge until the latched count runs out
// S_DONE  | one-cycle completion pulse; accepts load/start like IDLE
module seq_shift_register #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             shift_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;
    localparam logic [2:0] OP_SIL = 3'b110;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic             so_q;
    logic [2:0]       op_q;
    logic [AMT_W-1:0] cnt_q;

    logic [WIDTH-1:0] step_d;
    logic             bit_out_d;

    // Single-position result for the latched op; serial_in is sampled live on every step edge.
    always_comb begin
        step_d    = q_q;
        bit_out_d = so_q;
        case (op_q)
            OP_NOP: begin
                step_d    = q_q;
                bit_out_d = so_q;
            end
            OP_SLL: begin
                step_d    = {q_q[WIDTH-2:0], 1'b0};
                bit_out_d = q_q[WIDTH-1];
            end
            OP_SRL: begin
                step_d    = {1'b0, q_q[WIDTH-1:1]};
                bit_out_d = q_q[0];
            end
            OP_SRA: begin
                step_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                bit_out_d = q_q[0];
            end
            OP_ROL: begin
                step_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                bit_out_d = q_q[WIDTH-1];
            end
            OP_ROR: begin
                step_d    = {q_q[0], q_q[WIDTH-1:1]};
                bit_out_d = q_q[0];
            end
            OP_SIL: begin
                step_d    = {q_q[WIDTH-2:0], serial_in};
                bit_out_d = q_q[WIDTH-1];
            end
            default: begin
                step_d    = {serial_in, q_q[WIDTH-1:1]};
                bit_out_d = q_q[0];
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            so_q    <= 1'b0;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    if (!load_n) begin
                        q_q     <= data_in;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        q_q   <= step_d;
                        so_q  <= bit_out_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == AMT_W'(1)) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_IDLE, S_DONE: begin
                    // Load wins over start on the same edge.
                    if (!load_n) begin
                        q_q     <= data_in;
                        state_q <= S_IDLE;
                    end else if (start) begin
                        op_q    <= op;
                        cnt_q   <= amount;
                        state_q <= (amount != '0) ? S_SHIFT : S_DONE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign q         = q_q;
    assign shift_out = so_q;
    assign busy      = (state_q == S_SHIFT);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_shift_register.sv
// Directed bench for seq_shift_register: hand-computed vectors checked with immediate assertions.
module tb_seq_shift_register;

    localparam int W = 8;
    localparam int A = 4;

    logic         clock = 1'b0;
    logic         resetn;
    logic         load_n;
    logic [W-1:0] data_in;
    logic         start;
    logic [2:0]   op;
    logic [A-1:0] amount;
    logic         serial_in;
    logic [W-1:0] q;
    logic         shift_out;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;
    logic seen_done;

    seq_shift_register #(.WIDTH(W), .AMT_W(A)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .load_n   (load_n),
        .data_in  (data_in),
        .start    (start),
        .op       (op),
        .amount   (amount),
        .serial_in(serial_in),
        .q        (q),
        .shift_out(shift_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then back to the falling edge where inputs change and outputs are sampled.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_load(input logic [W-1:0] d);
        load_n  = 1'b0;
        data_in = d;
        step();
        load_n  = 1'b1;
    endtask

    task automatic do_start(input logic [2:0] o, input logic [A-1:0] a);
        start  = 1'b1;
        op     = o;
        amount = a;
        step();
        start  = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; load_n = 1'b1; data_in = '0; start = 1'b0;
        op = 3'b000; amount = '0; serial_in = 1'b0;
        #12;
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_so", shift_out, 0);
        @(negedge clock);
        resetn = 1'b1;
        step();

        // Reset in the middle of a ROR sequence
        do_load(8'hA5);
        chk("mid_load", q, 8'hA5);
        do_start(3'b101, 4'd5);
        chk("mid_busy0", busy, 1);
        chk("mid_q0", q, 8'hA5);
        step();
        chk("mid_step1", q, 8'hD2);
        step();
        chk("mid_step2", q, 8'h69);
        resetn = 1'b0;
        #1;
        chk("mid_rst_q", q, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clock);
        resetn = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) seen_done = 1'b1;
        end
        chk("mid_no_done", seen_done, 0);
        chk("mid_q_after", q, 0);

        // ROR 8'h81 by 3
        do_load(8'h81);
        do_start(3'b101, 4'd3);
        chk("ror_busy0", busy, 1);
        step();
        chk("ror_q1", q, 8'hC0);
        chk("ror_so1", shift_out, 1);
        chk("ror_busy1", busy, 1);
        step();
        chk("ror_q2", q, 8'h60);
        chk("ror_busy2", busy, 1);
        step();
        chk("ror_q3", q, 8'h30);
        chk("ror_busy3", busy, 0);
        chk("ror_done", done, 1);
        chk("ror_so3", shift_out, 0);
        step();
        chk("ror_done_clr", done, 0);
        chk("ror_idle_busy", busy, 0);
        chk("ror_hold", q, 8'h30);

        // SRA sign fill, then saturation with amount > WIDTH started straight from DONE
        do_load(8'h90);
        do_start(3'b011, 4'd2);
        step();
        chk("sra_q1", q, 8'hC8);
        step();
        chk("sra_q2", q, 8'hE4);
        chk("sra_done", done, 1);
        do_start(3'b011, 4'd12);
        chk("sra12_busy", busy, 1);
        repeat (12) step();
        chk("sra12_q", q, 8'hFF);
        chk("sra12_so", shift_out, 1);
        chk("sra12_done", done, 1);
        step();
        chk("sra12_so_hold", shift_out, 1);

        // Serial left with serial_in 1,0,1,1
        do_load(8'h00);
        chk("load_keeps_so", shift_out, 1);
        do_start(3'b110, 4'd4);
        serial_in = 1'b1; step();
        serial_in = 1'b0; step();
        serial_in = 1'b1; step();
        serial_in = 1'b1; step();
        serial_in = 1'b0;
        chk("sil_q", q, 8'h0B);
        chk("sil_done", done, 1);
        chk("sil_so", shift_out, 0);

        // Zero amount goes straight to DONE
        do_start(3'b001, 4'd0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_q", q, 8'h0B);
        step();
        chk("zero_done_clr", done, 0);

        // Load beats start on the same edge
        load_n = 1'b0; data_in = 8'h3C; start = 1'b1; op = 3'b001; amount = 4'd3;
        step();
        load_n = 1'b1; start = 1'b0;
        chk("prio_q", q, 8'h3C);
        chk("prio_busy", busy, 0);
        step();
        chk("prio_busy2", busy, 0);
        chk("prio_q2", q, 8'h3C);

        // Abort: SLL by 6, ignored restart with different op/amount, then load
        do_load(8'h01);
        do_start(3'b001, 4'd6);
        step();
        chk("abort_q1", q, 8'h02);
        step();
        chk("abort_q2", q, 8'h04);
        start = 1'b1; op = 3'b010; amount = 4'd1;
        step();
        start = 1'b0;
        chk("abort_ign_q", q, 8'h08);
        chk("abort_ign_busy", busy, 1);
        load_n = 1'b0; data_in = 8'h55;
        step();
        load_n = 1'b1;
        chk("abort_q", q, 8'h55);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || busy) seen_done = 1'b1;
        end
        chk("abort_no_done", seen_done, 0);
        chk("abort_q_hold", q, 8'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
